// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours: the IF/ID
// instruction, the register-file read and write-back ports, the EX flush
// input, the fetch stall output and the ID/EX pipeline register contents.
interface decode_stage_if;
    // IF/ID side
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;

    // Register file read ports
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;

    // Write-back port (same nets that drive WE3/A3/WD3)
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;

    // Pipeline control
    logic        flush_e;
    logic        stall;

    // ID/EX register
    logic        valid_e;
    logic [31:0] pc_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic [6:0]  opcode_e;
    logic [2:0]  funct3_e;
    logic        funct7b5_e;
    logic        regwrite_e;
    logic        memread_e;
    logic        memwrite_e;

    // Seen from the decode stage
    modport slave (
        input  instr_d, pc_d, valid_d, RD1, RD2, wb_we, wb_rd, wb_wdata, flush_e,
        output A1, A2, stall,
        output valid_e, pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
        output opcode_e, funct3_e, funct7b5_e, regwrite_e, memread_e, memwrite_e
    );

    // Seen from the surrounding pipeline
    modport master (
        output instr_d, pc_d, valid_d, RD1, RD2, wb_we, wb_rd, wb_wdata, flush_e,
        input  A1, A2, stall,
        input  valid_e, pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
        input  opcode_e, funct3_e, funct7b5_e, regwrite_e, memread_e, memwrite_e
    );
endinterface

// File: rtl/decode_stage.sv
// RV32 instruction-decode stage: drives register-file read addresses,
// builds immediates and control bits, bypasses same-cycle write-back data,
// detects load-use hazards and captures everything into ID/EX.
module decode_stage (
    input  logic          clk,
    input  logic          nrst,
    decode_stage_if.slave bus
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I_ALU  = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111
    } opcode_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } idex_t;

    logic [31:0] instr;
    logic [4:0]  rd_field;
    logic [31:0] imm;
    logic        regwrite_dec;
    logic        memread_dec;
    logic        memwrite_dec;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        hz;
    idex_t       idex_d;
    idex_t       idex_q;

    assign instr    = bus.instr_d;
    assign rd_field = instr[11:7];

    // Read addresses follow instr_d unconditionally
    assign bus.A1 = instr[19:15];
    assign bus.A2 = instr[24:20];

    // Decode opcode into immediate, control bits and source-register usage
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        imm          = '0;
        regwrite_dec = 1'b0;
        memread_dec  = 1'b0;
        memwrite_dec = 1'b0;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (instr[6:0])
            OP_R: begin
                regwrite_dec = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_I_ALU, OP_JALR: begin
                regwrite_dec = 1'b1;
                uses_rs1     = 1'b1;
                imm          = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                regwrite_dec = 1'b1;
                memread_dec  = 1'b1;
                uses_rs1     = 1'b1;
                imm          = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                memwrite_dec = 1'b1;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                imm          = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                regwrite_dec = 1'b1;
                imm          = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                regwrite_dec = 1'b1;
                imm          = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Write-back bypass: the file updates at the edge, so same-cycle data
    // must be steered around it; x0 always reads as zero.
    function automatic logic [31:0] bypass(input logic [4:0]  addr,
                                           input logic [31:0] rf_data,
                                           input logic        we,
                                           input logic [4:0]  wr_addr,
                                           input logic [31:0] wr_data);
        if (addr == 5'd0)
            return 32'd0;
        else if (we && (wr_addr == addr))
            return wr_data;
        else
            return rf_data;
    endfunction

    assign op1 = bypass(bus.A1, bus.RD1, bus.wb_we, bus.wb_rd, bus.wb_wdata);
    assign op2 = bypass(bus.A2, bus.RD2, bus.wb_we, bus.wb_rd, bus.wb_wdata);

    // Load-use hazard against the load currently sitting in ID/EX
    assign hz = bus.valid_d && idex_q.valid && idex_q.memread && (idex_q.rd != 5'd0) &&
                ((uses_rs1 && (bus.A1 == idex_q.rd)) ||
                 (uses_rs2 && (bus.A2 == idex_q.rd)));

    // A flush squashes IF/ID upstream, so no stall is needed then
    assign bus.stall = hz && !bus.flush_e;

    // Next ID/EX contents: bubble on flush, hazard or invalid input
    always_comb begin
        idex_d = '0;
        if (!(bus.flush_e || hz) && bus.valid_d) begin
            idex_d.valid    = 1'b1;
            idex_d.pc       = bus.pc_d;
            idex_d.rd1      = op1;
            idex_d.rd2      = op2;
            idex_d.imm      = imm;
            idex_d.rs1      = bus.A1;
            idex_d.rs2      = bus.A2;
            idex_d.rd       = rd_field;
            idex_d.opcode   = instr[6:0];
            idex_d.funct3   = instr[14:12];
            idex_d.funct7b5 = instr[30];
            idex_d.regwrite = regwrite_dec && (rd_field != 5'd0);
            idex_d.memread  = memread_dec;
            idex_d.memwrite = memwrite_dec;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: this is a small control/data register, so the whole thing is reset; stall depends on valid_e.
        if (!nrst)
            idex_q <= '0;
        else
            // NOTE: non-blocking so every flop samples pre-edge values.
            idex_q <= idex_d;
    end

    assign bus.valid_e    = idex_q.valid;
    assign bus.pc_e       = idex_q.pc;
    assign bus.rd1_e      = idex_q.rd1;
    assign bus.rd2_e      = idex_q.rd2;
    assign bus.imm_e      = idex_q.imm;
    assign bus.rs1_e      = idex_q.rs1;
    assign bus.rs2_e      = idex_q.rs2;
    assign bus.rd_e       = idex_q.rd;
    assign bus.opcode_e   = idex_q.opcode;
    assign bus.funct3_e   = idex_q.funct3;
    assign bus.funct7b5_e = idex_q.funct7b5;
    assign bus.regwrite_e = idex_q.regwrite;
    assign bus.memread_e  = idex_q.memread;
    assign bus.memwrite_e = idex_q.memwrite;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of single-instruction vectors
// followed by hand-written hazard, flush and reset sequences.
module tb_decode_stage;

    logic clk;
    logic nrst;
    int   checks;
    int   errors;

    decode_stage_if bus ();

    decode_stage dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wdata;
        logic [4:0]  exp_a1;
        logic        exp_valid;
        logic [31:0] exp_imm;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [4:0]  exp_rd;
        logic        exp_rw;
        logic        exp_mr;
        logic        exp_mw;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    localparam logic [31:0] LW_X3_0_X1  = 32'h0000A183;
    localparam logic [31:0] LW_X2_0_X1  = 32'h0000A103;
    localparam logic [31:0] LW_X0_0_X1  = 32'h0000A003;
    localparam logic [31:0] ADD_X4_X3X2 = 32'h00218233;
    localparam logic [31:0] ADD_X4_X0X0 = 32'h00000233;
    localparam logic [31:0] LUI_X3      = 32'h123451B7;
    localparam logic [31:0] ADDI_X8_X7  = 32'h00138413;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.instr_d  = ins;
        bus.pc_d     = pc;
        bus.valid_d  = 1'b1;
        bus.RD1      = r1;
        bus.RD2      = r2;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_wdata = 32'd0;
        bus.flush_e  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid_e"},    {31'd0, bus.valid_e},    32'd0);
        check({tag, ".pc_e"},       bus.pc_e,                32'd0);
        check({tag, ".rd1_e"},      bus.rd1_e,               32'd0);
        check({tag, ".rd2_e"},      bus.rd2_e,               32'd0);
        check({tag, ".imm_e"},      bus.imm_e,               32'd0);
        check({tag, ".rd_e"},       {27'd0, bus.rd_e},       32'd0);
        check({tag, ".rs1_e"},      {27'd0, bus.rs1_e},      32'd0);
        check({tag, ".opcode_e"},   {25'd0, bus.opcode_e},   32'd0);
        check({tag, ".regwrite_e"}, {31'd0, bus.regwrite_e}, 32'd0);
        check({tag, ".memread_e"},  {31'd0, bus.memread_e},  32'd0);
        check({tag, ".memwrite_e"}, {31'd0, bus.memwrite_e}, 32'd0);
        check({tag, ".stall"},      {31'd0, bus.stall},      32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            instr         pc          v  RD1        RD2        we  wb_rd  wb_wdata     a1  ev  imm           rd1        rd2        rd  rw mr mw
        vecs[0]  = '{32'hFFF00293, 32'h100, 1, 32'h0,     32'h22, 0, 5'd0, 32'h0,     5'd0,  1, 32'hFFFFFFFF, 32'h0,     32'h22,   5'd5,  1, 0, 0}; // ADDI x5,x0,-1
        vecs[1]  = '{ADDI_X8_X7,   32'h104, 1, 32'h11,    32'h22, 1, 5'd7, 32'hABCD,  5'd7,  1, 32'h1,        32'hABCD,  32'h22,   5'd8,  1, 0, 0}; // bypass op1
        vecs[2]  = '{32'hFFF00293, 32'h108, 1, 32'h0,     32'h22, 1, 5'd0, 32'hDEAD,  5'd0,  1, 32'hFFFFFFFF, 32'h0,     32'h22,   5'd5,  1, 0, 0}; // wb to x0
        vecs[3]  = '{ADD_X4_X3X2,  32'h10C, 1, 32'h33,    32'h22, 1, 5'd2, 32'h5555,  5'd3,  1, 32'h0,        32'h33,    32'h5555, 5'd4,  1, 0, 0}; // bypass op2
        vecs[4]  = '{32'h40208333, 32'h110, 1, 32'h11,    32'h22, 0, 5'd1, 32'h9999,  5'd1,  1, 32'h0,        32'h11,    32'h22,   5'd6,  1, 0, 0}; // SUB, wb_we=0
        vecs[5]  = '{32'hFE20AE23, 32'h114, 1, 32'h11,    32'h22, 0, 5'd0, 32'h0,     5'd1,  1, 32'hFFFFFFFC, 32'h11,    32'h22,   5'd28, 0, 0, 1}; // SW x2,-4(x1)
        vecs[6]  = '{32'hFE208EE3, 32'h118, 1, 32'h11,    32'h22, 0, 5'd0, 32'h0,     5'd1,  1, 32'hFFFFFFFC, 32'h11,    32'h22,   5'd29, 0, 0, 0}; // BEQ -4
        vecs[7]  = '{32'h001000EF, 32'h11C, 1, 32'h0,     32'h22, 0, 5'd0, 32'h0,     5'd0,  1, 32'h00000800, 32'h0,     32'h22,   5'd1,  1, 0, 0}; // JAL +2048
        vecs[8]  = '{LUI_X3,       32'h120, 1, 32'h88,    32'h22, 0, 5'd0, 32'h0,     5'd8,  1, 32'h12345000, 32'h88,    32'h22,   5'd3,  1, 0, 0}; // LUI
        vecs[9]  = '{32'hFFFFF517, 32'h124, 1, 32'h31,    32'h22, 0, 5'd0, 32'h0,     5'd31, 1, 32'hFFFFF000, 32'h31,    32'h22,   5'd10, 1, 0, 0}; // AUIPC
        vecs[10] = '{32'h00C280E7, 32'h128, 1, 32'h55,    32'h22, 0, 5'd0, 32'h0,     5'd5,  1, 32'h0000000C, 32'h55,    32'h22,   5'd1,  1, 0, 0}; // JALR
        vecs[11] = '{32'h00500013, 32'h12C, 1, 32'h0,     32'h22, 0, 5'd0, 32'h0,     5'd0,  1, 32'h5,        32'h0,     32'h22,   5'd0,  0, 0, 0}; // ADDI x0
        vecs[12] = '{32'hFFFFFFFF, 32'h130, 1, 32'h0,     32'h0,  0, 5'd0, 32'h0,     5'd31, 1, 32'h0,        32'h0,     32'h0,    5'd31, 0, 0, 0}; // unknown op
        vecs[13] = '{32'hFFF00293, 32'h134, 0, 32'h0,     32'h22, 0, 5'd0, 32'h0,     5'd0,  0, 32'h0,        32'h0,     32'h0,    5'd0,  0, 0, 0}; // valid_d=0

        // Reset
        nrst = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        bus.valid_d = 1'b0;
        #2;
        check_all_zero("reset");
        #10;
        nrst = 1'b1;
        step();

        // Table-driven single-instruction vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rd1, vecs[i].rd2);
            bus.valid_d  = vecs[i].valid;
            bus.wb_we    = vecs[i].wb_we;
            bus.wb_rd    = vecs[i].wb_rd;
            bus.wb_wdata = vecs[i].wb_wdata;
            #1;
            check($sformatf("v%0d.A1", i), {27'd0, bus.A1}, {27'd0, vecs[i].exp_a1});
            check($sformatf("v%0d.stall", i), {31'd0, bus.stall}, 32'd0);
            step();
            check($sformatf("v%0d.valid_e", i),    {31'd0, bus.valid_e},    {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d.pc_e", i),       bus.pc_e,                vecs[i].exp_valid ? vecs[i].pc : 32'd0);
            check($sformatf("v%0d.imm_e", i),      bus.imm_e,               vecs[i].exp_imm);
            check($sformatf("v%0d.rd1_e", i),      bus.rd1_e,               vecs[i].exp_rd1);
            check($sformatf("v%0d.rd2_e", i),      bus.rd2_e,               vecs[i].exp_rd2);
            check($sformatf("v%0d.rd_e", i),       {27'd0, bus.rd_e},       {27'd0, vecs[i].exp_rd});
            check($sformatf("v%0d.regwrite_e", i), {31'd0, bus.regwrite_e}, {31'd0, vecs[i].exp_rw});
            check($sformatf("v%0d.memread_e", i),  {31'd0, bus.memread_e},  {31'd0, vecs[i].exp_mr});
            check($sformatf("v%0d.memwrite_e", i), {31'd0, bus.memwrite_e}, {31'd0, vecs[i].exp_mw});
        end

        // SUB carries funct7 bit 5 and R-type opcode through
        drive(32'h40208333, 32'h140, 32'h1, 32'h2);
        step();
        check("sub.funct7b5_e", {31'd0, bus.funct7b5_e}, 32'd1);
        check("sub.opcode_e",   {25'd0, bus.opcode_e},   32'h33);

        // Load-use on rs1: one stall cycle, bubble, then the ADD enters EX
        drive(LW_X3_0_X1, 32'h200, 32'h0, 32'h0);
        step();
        check("lu1.memread_e", {31'd0, bus.memread_e}, 32'd1);
        drive(ADD_X4_X3X2, 32'h204, 32'h33, 32'h22);
        #1;
        check("lu1.stall", {31'd0, bus.stall}, 32'd1);
        step();
        check("lu1.bubble_valid", {31'd0, bus.valid_e},   32'd0);
        check("lu1.bubble_mr",    {31'd0, bus.memread_e}, 32'd0);
        check("lu1.stall_drop",   {31'd0, bus.stall},     32'd0);
        step();
        check("lu1.add_valid", {31'd0, bus.valid_e}, 32'd1);
        check("lu1.add_rd",    {27'd0, bus.rd_e},    32'd4);
        check("lu1.add_rs1",   {27'd0, bus.rs1_e},   32'd3);
        check("lu1.add_pc",    bus.pc_e,             32'h204);
        check("lu1.add_rd1",   bus.rd1_e,            32'h33);

        // Load-use on rs2
        drive(LW_X2_0_X1, 32'h208, 32'h0, 32'h0);
        step();
        drive(ADD_X4_X3X2, 32'h20C, 32'h33, 32'h22);
        #1;
        check("lu2.stall", {31'd0, bus.stall}, 32'd1);
        step();
        check("lu2.bubble_valid", {31'd0, bus.valid_e}, 32'd0);

        // Load to x0 never creates a hazard
        drive(LW_X0_0_X1, 32'h210, 32'h0, 32'h0);
        step();
        drive(ADD_X4_X0X0, 32'h214, 32'h0, 32'h0);
        #1;
        check("lx0.stall", {31'd0, bus.stall}, 32'd0);
        step();
        check("lx0.valid_e", {31'd0, bus.valid_e}, 32'd1);

        // LUI does not read registers, even though its A2 field matches rd_e
        drive(LW_X3_0_X1, 32'h218, 32'h0, 32'h0);
        step();
        drive(LUI_X3, 32'h21C, 32'h0, 32'h0);
        #1;
        check("lui.stall", {31'd0, bus.stall}, 32'd0);
        step();
        check("lui.valid_e", {31'd0, bus.valid_e}, 32'd1);
        check("lui.imm_e",   bus.imm_e,            32'h12345000);

        // Flush wins over a load-use hazard
        drive(LW_X3_0_X1, 32'h220, 32'h0, 32'h0);
        step();
        drive(ADD_X4_X3X2, 32'h224, 32'h33, 32'h22);
        bus.flush_e = 1'b1;
        #1;
        check("fl.stall", {31'd0, bus.stall}, 32'd0);
        step();
        check("fl.valid_e",    {31'd0, bus.valid_e},    32'd0);
        check("fl.regwrite_e", {31'd0, bus.regwrite_e}, 32'd0);

        // Flush squashes an ordinary instruction as well
        drive(ADDI_X8_X7, 32'h228, 32'h11, 32'h22);
        bus.flush_e = 1'b1;
        step();
        check("fl2.valid_e", {31'd0, bus.valid_e}, 32'd0);
        check("fl2.pc_e",    bus.pc_e,             32'd0);

        // Asynchronous reset in the middle of a stall
        drive(LW_X3_0_X1, 32'h300, 32'h0, 32'h0);
        step();
        drive(ADD_X4_X3X2, 32'h304, 32'h33, 32'h22);
        #1;
        check("rst.stall_before", {31'd0, bus.stall}, 32'd1);
        #1;
        nrst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        nrst = 1'b1;
        bus.valid_d = 1'b0;
        step();
        check("rst.after_valid", {31'd0, bus.valid_e}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the RISC-V core, sitting directly in front of the 32×32 register file. It splits the fetched instruction into register addresses that drive the file's read ports, and generates the immediate and control bits. It also bypasses same-cycle write-back data around the file and detects load-use hazards, inserting a bubble and stalling fetch when one occurs. The resulting operands and controls are captured into the ID/EX pipeline register for the execute stage.

## Interface
Parameters: none; XLEN is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  reset; asynchronous, active-low
- instr_d  in  32  instruction from the IF/ID register
- pc_d  in  32  PC of instr_d
- valid_d  in  1  instr_d is a real instruction
- A1  out  5  register file read address 1 = instr_d[19:15]
- A2  out  5  register file read address 2 = instr_d[24:20]
- RD1, RD2  in  32  register file read data for A1/A2
- wb_we, wb_rd, wb_wdata  in  1/5/32  write-back port; the same signals that drive WE3/A3/WD3
- flush_e  in  1  taken branch/jump in EX; squash the instruction entering EX
- stall  out  1  hold PC and IF/ID (combinational)
- valid_e  out  1  ID/EX holds a real instruction
- pc_e, rd1_e, rd2_e, imm_e  out  32  registered PC, operands and immediate
- rs1_e, rs2_e, rd_e  out  5  registered register addresses
- opcode_e  out  7  registered opcode
- funct3_e  out  3  registered funct3
- funct7b5_e  out  1  registered instr[30]
- regwrite_e, memread_e, memwrite_e  out  1  registered control bits

## Operation
- A1/A2 are driven combinationally from instr_d at all times, whether or not valid_d is set.

Decode rules (opcode → fields):
- R 0110011: regwrite, uses rs1 and rs2, imm=0.
- I-ALU 0010011 and JALR 1100111: regwrite, uses rs1, I-immediate.
- Load 0000011: regwrite, memread, uses rs1, I-immediate.
- Store 0100011: memwrite, uses rs1 and rs2, S-immediate.
- Branch 1100011: uses rs1 and rs2, B-immediate (bit 0 = 0).
- LUI 0110111 and AUIPC 0010111: regwrite, U-immediate ({instr[31:12],12'b0}).
- JAL 1101111: regwrite, J-immediate (bit 0 = 0).
- Any other opcode: all control bits 0, imm=0, but valid is still propagated.
- All immediates are sign-extended from instr[31].
- rd=0 forces regwrite_e=0.

Bypass (register file writes at the clock edge; reads are combinational):
- Operand 1 = wb_wdata if wb_we & wb_rd≠0 & wb_rd==A1, else RD1.
- Operand 2 is formed the same way using A2 and RD2.
- Address 0 always yields 0, even if wb_we targets x0.

Load-use hazard:
- hz = valid_d & valid_e & memread_e & rd_e≠0 & ((uses_rs1 & A1==rd_e) | (uses_rs2 & A2==rd_e)).
- stall = hz & ~flush_e.

ID/EX register update each rising edge:
- If flush_e or hz: load a bubble (valid_e=0, regwrite/memread/memwrite=0; all other fields 0).
- Else if valid_d: load the decoded fields and operands, and set valid_e=1.
- Else: load a bubble.

## Timing
- Reset (nrst low, asynchronous): every registered output is 0; stall is 0 once valid_e=0.
- Latency: an instruction on instr_d appears on the *_e outputs 1 cycle later.
- Stall lasts exactly 1 cycle per load-use hazard. The bubble clears memread_e, so the held instruction proceeds on the next edge. Its operand then arrives through the WB bypass or through a later forwarding stage.
- flush_e and hz in the same cycle: flush takes priority and stall=0, because upstream squashes IF/ID itself.
- Bypass and stall are purely combinational within the cycle; there is no extra latency.
- nrst asserted mid-stall: outputs clear immediately and stall drops with them.

## Test plan
- Reset, then ADDI x5,x0,-1 (0xFFF00293) with valid_d=1 → next cycle: valid_e=1, imm_e=0xFFFFFFFF, rd_e=5, regwrite_e=1, memread_e=0.
- Same-cycle bypass: RD1=0x11, wb_we=1, wb_rd=A1=7, wb_wdata=0xABCD → rd1_e=0xABCD. Repeat with wb_rd=0 and A1=0 → rd1_e = RD1 (0 from the file).
- Load-use: LW x3,0(x1) then ADD x4,x3,x2 → stall=1 for one cycle; ID/EX holds a bubble (valid_e=0); the ADD enters EX on the following cycle.
- No false hazard: LW x3 then LUI x3,0x12345 → stall=0; imm_e=0x12345000.
- Flush priority: hz condition true with flush_e=1 → stall=0; valid_e=0 next cycle.
- Immediates: BEQ with offset -4 → imm_e=0xFFFFFFFC. JAL with offset +2048 → imm_e=0x00000800. Assert nrst low mid-sequence → all *_e outputs 0 asynchronously.
